acc_index_regs: RTL and testbench
=================================

ACC_INDEX_REGS -- requirements
Module: acc_index_regs

Interface
REQ-001 Parameter DW, default 4: width of the accumulator, temp and each index register.
REQ-002 Parameter NREGS, default 16: index register count; SHALL be an even power of two ≥ 2.
REQ-003 Parameter RAW, default $clog2(NREGS): index register address width.
REQ-004 clk  input  1  sole clock; all state changes on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 alu_result  input  DW  ALU data result.
REQ-007 alu_carry  input  1  ALU carry/borrow result.
REQ-008 acc_we / temp_we / carry_we  input  1 each  load ACC / Temp / Carry from the ALU.
REQ-009 rsel  input  RAW  selects the index register for reg_out, reg_we and xch.
REQ-010 reg_we  input  1  write ACC into reg[rsel].
REQ-011 xch  input  1  exchange ACC with reg[rsel].
REQ-012 pair_start  input  1  begin a two-nibble pair load.
REQ-013 pair_sel  input  RAW-1  target pair p, covering regs 2p (high) and 2p+1 (low); sampled on an accepted pair_start.
REQ-014 pair_abort  input  1  cancel an in-flight pair load.
REQ-015 nib_in / nib_valid  input  DW / 1  nibble bus and its qualifier.
REQ-016 acc_out / temp_out  output  DW  registered ACC / Temp.
REQ-017 carry_out  output  1  registered carry flag.
REQ-018 reg_out  output  DW  combinational reg[rsel].
REQ-019 pair_out  output  2*DW  combinational {reg[2*pair_sel], reg[2*pair_sel+1]}.
REQ-020 pair_busy  output  1  high whenever the FSM is not IDLE.
REQ-021 pair_done  output  1  one-cycle pulse in the cycle after a pair commit edge.

Function
REQ-022 With acc_we=1 and xch=0, ACC SHALL load alu_result at the next edge; with temp_we=1, Temp SHALL load alu_result; with carry_we=1, Carry SHALL load alu_carry; otherwise each SHALL hold.
REQ-023 With xch=1, ACC SHALL load the old reg[rsel] and reg[rsel] SHALL load the old ACC in the same edge; xch SHALL override acc_we and reg_we.
REQ-024 With reg_we=1 and xch=0, reg[rsel] SHALL load the current ACC.
REQ-025 FSM states: IDLE, HI, LO; the pair_sel captured at the accepted pair_start SHALL be held in a pointer register.
REQ-026 IDLE->HI on pair_start; pair_start while busy SHALL be ignored and SHALL NOT re-capture pair_sel.
REQ-027 HI->LO on nib_valid, latching nib_in into a staging register; nib_valid in IDLE SHALL be ignored.
REQ-028 LO->IDLE on nib_valid: reg[2p] SHALL load the staged nibble and reg[2p+1] SHALL load nib_in atomically at the same edge; pair_done SHALL be 1 in the following cycle.
REQ-029 Minimum pair load: 3 edges (start, hi, lo); the FSM SHALL wait indefinitely in HI/LO without nib_valid.
REQ-030 pair_abort in HI or LO SHALL return the FSM to IDLE with no register write and no pair_done; it SHALL override a simultaneous nib_valid.
REQ-031 Commit collision: if reg_we or xch targets reg 2p or 2p+1 at the commit edge, the pair write SHALL win for that register; the ACC side of xch SHALL still complete.
REQ-032 Index registers SHALL NOT be otherwise modified while busy; reg_we/xch to other registers SHALL proceed normally.
REQ-033 All arithmetic is external; no wrap or saturation logic inside this block.

Reset
REQ-034 rst=1 at an edge SHALL clear ACC, Temp, Carry, all index registers, staging and pointer to 0; FSM to IDLE; pair_busy=0 and pair_done=0.
REQ-035 Reset SHALL take priority over every other input, including mid-pair-load, and SHALL discard partial loads.

Structure
REQ-036 The FSM state enum, and DW/NREGS defaults, SHALL live in the shared CPU package.
REQ-037 The nibble-pair loader (FSM, staging, pointer) SHALL be one sub-module, pair_loader, emitting a commit strobe, pair index and 2*DW data.

Verification
REQ-038 Reset, then acc_we=1, alu_result=4'hA, carry_we=1, alu_carry=1 -> acc_out=A, carry_out=1.
REQ-039 ACC=3, reg[5]=C, xch=1, rsel=5 -> acc_out=C, reg[5]=3 after one edge.
REQ-040 pair_start with pair_sel=2, then nib 4'h7, then nib 4'hE -> reg4=7, reg5=E, pair_out=8'h7E, pair_done pulses once, busy for 2 cycles before commit.
REQ-041 pair load to pair 1; at the commit edge reg_we=1, rsel=3, ACC=9 -> reg3 holds the pair low nibble, not 9.
REQ-042 pair_abort in LO with nib_valid=1 -> registers unchanged, no pair_done, busy=0 next cycle.
REQ-043 rst asserted in HI -> all outputs 0, FSM IDLE; a following nib_valid causes no write.

Source files
------------

// File: rtl/acc_index_regs_pkg.sv
// Shared definitions for the accumulator / index register slice:
// default geometry and the nibble-pair loader state encoding.
package acc_index_regs_pkg;

  localparam int DW_DEF    = 4;
  localparam int NREGS_DEF = 16;

  typedef enum logic [1:0] {
    PAIR_IDLE = 2'd0,
    PAIR_HI   = 2'd1,
    PAIR_LO   = 2'd2
  } pair_state_e;

endpackage

// File: rtl/acc_index_regs_if.sv
// Bus bundle between the datapath controller (master) and the
// accumulator / index register block (slave).
interface acc_index_regs_if #(
  parameter int DW  = acc_index_regs_pkg::DW_DEF,
  parameter int RAW = $clog2(acc_index_regs_pkg::NREGS_DEF)
) ();

  logic [DW-1:0]    alu_result;
  logic             alu_carry;
  logic             acc_we;
  logic             temp_we;
  logic             carry_we;
  logic [RAW-1:0]   rsel;
  logic             reg_we;
  logic             xch;
  logic             pair_start;
  logic [RAW-2:0]   pair_sel;
  logic             pair_abort;
  logic [DW-1:0]    nib_in;
  logic             nib_valid;

  logic [DW-1:0]    acc_out;
  logic [DW-1:0]    temp_out;
  logic             carry_out;
  logic [DW-1:0]    reg_out;
  logic [2*DW-1:0]  pair_out;
  logic             pair_busy;
  logic             pair_done;

  modport master (
    output alu_result, alu_carry, acc_we, temp_we, carry_we, rsel, reg_we, xch,
           pair_start, pair_sel, pair_abort, nib_in, nib_valid,
    input  acc_out, temp_out, carry_out, reg_out, pair_out, pair_busy, pair_done
  );

  modport slave (
    input  alu_result, alu_carry, acc_we, temp_we, carry_we, rsel, reg_we, xch,
           pair_start, pair_sel, pair_abort, nib_in, nib_valid,
    output acc_out, temp_out, carry_out, reg_out, pair_out, pair_busy, pair_done
  );

endinterface

// File: rtl/acc_index_regs_pair_loader.sv
// Two-nibble pair loader: collects a high then a low nibble and emits a
// single-cycle commit strobe with the target pair index and both nibbles.
module pair_loader
  import acc_index_regs_pkg::*;
#(
  parameter int DW  = DW_DEF,
  parameter int RAW = $clog2(NREGS_DEF)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [RAW-2:0]  sel,
  input  logic            abort,
  input  logic [DW-1:0]   nib_in,
  input  logic            nib_valid,
  output logic            busy,
  output logic            done,
  output logic            commit,
  output logic [RAW-2:0]  idx,
  output logic [2*DW-1:0] data
);

  pair_state_e    state_q;
  logic [DW-1:0]  stage_q;
  logic [RAW-2:0] ptr_q;
  logic           done_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= PAIR_IDLE;
      stage_q <= '0;
      ptr_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        PAIR_IDLE: begin
          if (start) begin
            ptr_q   <= sel;
            state_q <= PAIR_HI;
          end
        end
        PAIR_HI: begin
          if (abort) begin
            state_q <= PAIR_IDLE;
          end else if (nib_valid) begin
            stage_q <= nib_in;
            state_q <= PAIR_LO;
          end
        end
        PAIR_LO: begin
          // abort wins over a coincident low nibble
          if (abort) begin
            state_q <= PAIR_IDLE;
          end else if (nib_valid) begin
            state_q <= PAIR_IDLE;
            done_q  <= 1'b1;
          end
        end
        default: state_q <= PAIR_IDLE;
      endcase
    end
  end

  assign busy   = (state_q != PAIR_IDLE);
  assign done   = done_q;
  assign commit = (state_q == PAIR_LO) && nib_valid && !abort;
  assign idx    = ptr_q;
  assign data   = {stage_q, nib_in};

endmodule

// File: rtl/acc_index_regs.sv
// Accumulator, Temp, Carry and the index register file, with a nibble-pair
// loader that writes two adjacent index registers atomically.
module acc_index_regs
  import acc_index_regs_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int NREGS = NREGS_DEF,
  parameter int RAW   = $clog2(NREGS)
) (
  input logic                clk,
  input logic                rst,
  acc_index_regs_if.slave    bus
);

  logic [DW-1:0]   acc_q,  acc_d;
  logic [DW-1:0]   temp_q, temp_d;
  logic            carry_q, carry_d;
  logic [DW-1:0]   regs_q [NREGS];
  logic [DW-1:0]   regs_d [NREGS];

  logic            pl_busy;
  logic            pl_done;
  logic            pl_commit;
  logic [RAW-2:0]  pl_idx;
  logic [2*DW-1:0] pl_data;
  logic            pair_locked;

  pair_loader #(.DW(DW), .RAW(RAW)) u_pair_loader (
    .clk       (clk),
    .rst       (rst),
    .start     (bus.pair_start),
    .sel       (bus.pair_sel),
    .abort     (bus.pair_abort),
    .nib_in    (bus.nib_in),
    .nib_valid (bus.nib_valid),
    .busy      (pl_busy),
    .done      (pl_done),
    .commit    (pl_commit),
    .idx       (pl_idx),
    .data      (pl_data)
  );

  // The in-flight pair owns its two registers until it commits or aborts.
  assign pair_locked = pl_busy && (bus.rsel[RAW-1:1] == pl_idx);

  always_comb begin
    acc_d   = acc_q;
    temp_d  = temp_q;
    carry_d = carry_q;
    regs_d  = regs_q;

    if (bus.xch) begin
      acc_d = regs_q[bus.rsel];
    end else if (bus.acc_we) begin
      acc_d = bus.alu_result;
    end
    if (bus.temp_we)  temp_d  = bus.alu_result;
    if (bus.carry_we) carry_d = bus.alu_carry;

    // Both xch and reg_we store the pre-edge ACC into the selected register.
    if ((bus.xch || bus.reg_we) && !pair_locked) begin
      regs_d[bus.rsel] = acc_q;
    end

    if (pl_commit) begin
      regs_d[{pl_idx, 1'b0}] = pl_data[2*DW-1:DW];
      regs_d[{pl_idx, 1'b1}] = pl_data[DW-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      temp_q  <= '0;
      carry_q <= 1'b0;
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else begin
      acc_q   <= acc_d;
      temp_q  <= temp_d;
      carry_q <= carry_d;
      regs_q  <= regs_d;
    end
  end

  assign bus.acc_out   = acc_q;
  assign bus.temp_out  = temp_q;
  assign bus.carry_out = carry_q;
  assign bus.reg_out   = regs_q[bus.rsel];
  assign bus.pair_out  = {regs_q[{bus.pair_sel, 1'b0}], regs_q[{bus.pair_sel, 1'b1}]};
  assign bus.pair_busy = pl_busy;
  assign bus.pair_done = pl_done;

endmodule

// File: tb/tb_acc_index_regs.sv
// Directed and randomized bench for acc_index_regs against a behavioural model.
module tb_acc_index_regs;

  localparam int DW    = 4;
  localparam int NREGS = 16;
  localparam int RAW   = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #50 clk = ~clk;

  acc_index_regs_if #(.DW(DW), .RAW(RAW)) bus ();

  acc_index_regs #(.DW(DW), .NREGS(NREGS), .RAW(RAW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int checks = 0;
  int errors = 0;

  // Model state: phase 0 = no load, 1 = awaiting high nibble, 2 = awaiting low
  logic [3:0] m_acc, m_temp, m_stage;
  logic       m_carry, m_done;
  logic [3:0] m_regs [NREGS];
  int         m_phase, m_ptr;

  logic [3:0] n_acc, n_temp, n_stage;
  logic       n_carry, n_done;
  logic [3:0] n_regs [NREGS];
  int         n_phase, n_ptr;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_next();
    int  r;
    bit  owned;
    n_acc = m_acc; n_temp = m_temp; n_carry = m_carry; n_stage = m_stage;
    n_regs = m_regs; n_phase = m_phase; n_ptr = m_ptr; n_done = 1'b0;
    if (rst) begin
      n_acc = 0; n_temp = 0; n_carry = 0; n_stage = 0; n_phase = 0; n_ptr = 0;
      for (int i = 0; i < NREGS; i++) n_regs[i] = 0;
    end else begin
      r = int'(bus.rsel);
      owned = (m_phase != 0) && (r / 2 == m_ptr);
      if (bus.xch) n_acc = m_regs[r];
      else if (bus.acc_we) n_acc = bus.alu_result;
      if (bus.temp_we) n_temp = bus.alu_result;
      if (bus.carry_we) n_carry = bus.alu_carry;
      if ((bus.xch || bus.reg_we) && !owned) n_regs[r] = m_acc;
      if (m_phase == 0) begin
        if (bus.pair_start) begin n_phase = 1; n_ptr = int'(bus.pair_sel); end
      end else if (bus.pair_abort) begin
        n_phase = 0;
      end else if (bus.nib_valid) begin
        if (m_phase == 1) begin
          n_stage = bus.nib_in; n_phase = 2;
        end else begin
          n_regs[2*m_ptr]   = m_stage;
          n_regs[2*m_ptr+1] = bus.nib_in;
          n_phase = 0;
          n_done  = 1'b1;
        end
      end
    end
  endtask

  task automatic check_outputs();
    int ps;
    ps = int'(bus.pair_sel);
    chk("acc_out",   32'(bus.acc_out),   32'(m_acc));
    chk("temp_out",  32'(bus.temp_out),  32'(m_temp));
    chk("carry_out", 32'(bus.carry_out), 32'(m_carry));
    chk("pair_busy", 32'(bus.pair_busy), 32'(m_phase != 0));
    chk("pair_done", 32'(bus.pair_done), 32'(m_done));
    chk("reg_out",   32'(bus.reg_out),   32'(m_regs[int'(bus.rsel)]));
    chk("pair_out",  32'(bus.pair_out),  32'({m_regs[2*ps], m_regs[2*ps+1]}));
  endtask

  task automatic step();
    model_next();
    @(posedge clk);
    #1;
    m_acc = n_acc; m_temp = n_temp; m_carry = n_carry; m_stage = n_stage;
    m_regs = n_regs; m_phase = n_phase; m_ptr = n_ptr; m_done = n_done;
    check_outputs();
  endtask

  task automatic sweep_regs();
    logic [RAW-1:0] saved;
    saved = bus.rsel;
    for (int i = 0; i < NREGS; i++) begin
      bus.rsel = RAW'(i);
      #1;
      chk("reg_sweep", 32'(bus.reg_out), 32'(m_regs[i]));
    end
    bus.rsel = saved;
    #1;
  endtask

  task automatic idle_inputs();
    bus.alu_result = '0; bus.alu_carry = 1'b0;
    bus.acc_we = 1'b0; bus.temp_we = 1'b0; bus.carry_we = 1'b0;
    bus.reg_we = 1'b0; bus.xch = 1'b0;
    bus.pair_start = 1'b0; bus.pair_abort = 1'b0; bus.nib_valid = 1'b0;
    bus.nib_in = '0;
  endtask

  task automatic load_acc(input logic [3:0] v);
    bus.acc_we = 1'b1; bus.alu_result = v;
    step();
    idle_inputs();
  endtask

  initial begin
    idle_inputs();
    bus.rsel = '0;
    bus.pair_sel = '0;
    m_phase = 0; m_ptr = 0;

    // Reset
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    chk("rst_acc", 32'(bus.acc_out), 32'h0);
    chk("rst_busy", 32'(bus.pair_busy), 32'h0);
    sweep_regs();

    // ALU loads into ACC and Carry
    bus.acc_we = 1'b1; bus.alu_result = 4'hA; bus.carry_we = 1'b1; bus.alu_carry = 1'b1;
    step();
    chk("ld_acc", 32'(bus.acc_out), 32'hA);
    chk("ld_carry", 32'(bus.carry_out), 32'h1);
    idle_inputs();
    bus.temp_we = 1'b1; bus.alu_result = 4'h6;
    step();
    chk("ld_temp", 32'(bus.temp_out), 32'h6);
    idle_inputs();

    // Exchange ACC=3 with reg[5]=C
    load_acc(4'hC);
    bus.rsel = 4'd5; bus.reg_we = 1'b1;
    step();
    idle_inputs();
    load_acc(4'h3);
    bus.xch = 1'b1; bus.acc_we = 1'b1; bus.alu_result = 4'hF;
    step();
    idle_inputs();
    chk("xch_acc", 32'(bus.acc_out), 32'hC);
    chk("xch_reg5", 32'(bus.reg_out), 32'h3);

    // Pair load into pair 2
    bus.pair_sel = 3'd2; bus.pair_start = 1'b1;
    step();
    chk("pl_busy_hi", 32'(bus.pair_busy), 32'h1);
    bus.pair_start = 1'b0;
    step();
    chk("pl_wait_hi", 32'(bus.pair_busy), 32'h1);
    bus.nib_valid = 1'b1; bus.nib_in = 4'h7;
    step();
    chk("pl_busy_lo", 32'(bus.pair_busy), 32'h1);
    chk("pl_nodone", 32'(bus.pair_done), 32'h0);
    bus.nib_in = 4'hE;
    step();
    idle_inputs();
    chk("pl_done", 32'(bus.pair_done), 32'h1);
    chk("pl_idle", 32'(bus.pair_busy), 32'h0);
    chk("pl_out", 32'(bus.pair_out), 32'h7E);
    step();
    chk("pl_done_once", 32'(bus.pair_done), 32'h0);

    // Commit collision: reg_we to reg3 at the commit edge of pair 1
    load_acc(4'h9);
    bus.pair_sel = 3'd1; bus.pair_start = 1'b1;
    step();
    bus.pair_start = 1'b0; bus.nib_valid = 1'b1; bus.nib_in = 4'h5;
    step();
    bus.nib_in = 4'hB; bus.reg_we = 1'b1; bus.rsel = 4'd3;
    step();
    idle_inputs();
    chk("coll_reg3", 32'(bus.reg_out), 32'hB);
    chk("coll_pair1", 32'(bus.pair_out), 32'h5B);

    // Abort in LO with simultaneous nib_valid
    bus.pair_sel = 3'd3; bus.pair_start = 1'b1;
    step();
    bus.pair_start = 1'b0; bus.nib_valid = 1'b1; bus.nib_in = 4'h1;
    step();
    bus.nib_in = 4'h2; bus.pair_abort = 1'b1;
    step();
    idle_inputs();
    chk("abort_busy", 32'(bus.pair_busy), 32'h0);
    chk("abort_done", 32'(bus.pair_done), 32'h0);
    chk("abort_pair3", 32'(bus.pair_out), 32'h00);

    // Reset while in HI, then a stray nibble
    bus.pair_sel = 3'd4; bus.pair_start = 1'b1;
    step();
    bus.pair_start = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst_hi_busy", 32'(bus.pair_busy), 32'h0);
    chk("rst_hi_acc", 32'(bus.acc_out), 32'h0);
    bus.nib_valid = 1'b1; bus.nib_in = 4'hD;
    step();
    bus.nib_in = 4'h8;
    step();
    idle_inputs();
    chk("rst_hi_nowrite", 32'(bus.pair_out), 32'h00);
    sweep_regs();

    // Randomized traffic
    for (int c = 0; c < 600; c++) begin
      rst            = ($urandom_range(0, 99) == 0);
      bus.alu_result = 4'($urandom);
      bus.alu_carry  = 1'($urandom);
      bus.acc_we     = ($urandom_range(0, 2) == 0);
      bus.temp_we    = ($urandom_range(0, 3) == 0);
      bus.carry_we   = ($urandom_range(0, 3) == 0);
      bus.rsel       = 4'($urandom);
      bus.reg_we     = ($urandom_range(0, 3) == 0);
      bus.xch        = ($urandom_range(0, 5) == 0);
      bus.pair_start = ($urandom_range(0, 3) == 0);
      bus.pair_sel   = 3'($urandom);
      bus.pair_abort = ($urandom_range(0, 9) == 0);
      bus.nib_in     = 4'($urandom);
      bus.nib_valid  = ($urandom_range(0, 1) == 0);
      step();
      if (c % 100 == 99) begin
        rst = 1'b0;
        idle_inputs();
        sweep_regs();
      end
    end
    rst = 1'b0;
    idle_inputs();
    step();
    sweep_regs();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
